// File: rtl/spio_status_led_scheduler.sv
// ============================================================================
// spio_status_led_scheduler
//
// Purpose
//   Time-multiplexes the status of NUM_LEDS x NUM_GROUPS devices onto the
//   NUM_LEDS-wide inputs of the board's status LED generator. The group
//   shown on the LEDs only changes on the generator's end-of-animation
//   pulse, so a running animation is never cut short. Groups that contain
//   an errored device are shown preferentially. Activity seen on a device
//   whose group is not on display is remembered, then replayed as a single
//   pulse when that group is next shown.
//
//   Device numbering: d = g*NUM_LEDS + k  (group g, LED k).
//
// Ports
//   CLK_IN               in   1            single clock
//   RESET_IN             in   1            synchronous, active-high reset
//   ERROR_IN             in   LEDS*GROUPS  per-device error level
//   CONNECTED_IN         in   LEDS*GROUPS  per-device connected level
//   ACTIVITY_IN          in   LEDS*GROUPS  per-device activity pulses
//   ANIMATION_REPEAT_IN  in   1            end-of-animation pulse from generator
//   LED_ERROR_OUT        out  NUM_LEDS     to generator ERROR_IN
//   LED_CONNECTED_OUT    out  NUM_LEDS     to generator CONNECTED_IN
//   LED_ACTIVITY_OUT     out  NUM_LEDS     to generator ACTIVITY_IN
//   GROUP_OUT            out  GROUP_BITS   group shown on the LED_* outputs
//   STATE_OUT            out  1            debug view of the scheduler state
//                                          (0 = SCAN rotation, 1 = ERROR)
//
// Handshake
//   There is no valid/ready handshake. ANIMATION_REPEAT_IN is a one-cycle
//   strobe that is acted on in exactly the cycle it is high; ACTIVITY_IN
//   bits are one-cycle strobes; ERROR_IN and CONNECTED_IN are levels.
//
// Timing
//   The edge that samples ANIMATION_REPEAT_IN=1 updates the group register;
//   the LED_* outputs and GROUP_OUT all switch together one edge later, so
//   they always describe the same group.
// ============================================================================
module spio_status_led_scheduler #(
    parameter int NUM_LEDS      = 4,
    parameter int NUM_GROUPS    = 2,
    parameter int GROUP_BITS    = 1,
    parameter int DWELL_PERIODS = 2,
    parameter int DWELL_BITS    = 2
) (
    input  logic                           CLK_IN,
    input  logic                           RESET_IN,
    input  logic [NUM_LEDS*NUM_GROUPS-1:0] ERROR_IN,
    input  logic [NUM_LEDS*NUM_GROUPS-1:0] CONNECTED_IN,
    input  logic [NUM_LEDS*NUM_GROUPS-1:0] ACTIVITY_IN,
    input  logic                           ANIMATION_REPEAT_IN,
    output logic [NUM_LEDS-1:0]            LED_ERROR_OUT,
    output logic [NUM_LEDS-1:0]            LED_CONNECTED_OUT,
    output logic [NUM_LEDS-1:0]            LED_ACTIVITY_OUT,
    output logic [GROUP_BITS-1:0]          GROUP_OUT,
    output logic                           STATE_OUT
);

    // The group index can address more slots than there are groups; the
    // spare slots read as "no devices" so indexing by group_q is always safe.
    localparam int NUM_SLOTS = 1 << GROUP_BITS;
    localparam int NUM_DEVS  = NUM_LEDS * NUM_GROUPS;

    localparam logic [GROUP_BITS-1:0] LAST_GROUP = GROUP_BITS'(NUM_GROUPS - 1);
    localparam logic [DWELL_BITS-1:0] LAST_DWELL = DWELL_BITS'(DWELL_PERIODS - 1);

    typedef enum logic {
        ST_SCAN  = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t                  state;
    logic [GROUP_BITS-1:0]   group_q;
    logic [DWELL_BITS-1:0]   dwell_q;
    logic [NUM_DEVS-1:0]     pending;

    // ------------------------------------------------------------------------
    // Per-group views of the device vectors
    // ------------------------------------------------------------------------
    logic [NUM_LEDS-1:0]     slot_err [NUM_SLOTS];
    logic [NUM_LEDS-1:0]     slot_con [NUM_SLOTS];
    logic [NUM_LEDS-1:0]     slot_act [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    err_grp;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        if (g < NUM_GROUPS) begin : g_real
            assign slot_err[g] = ERROR_IN[g*NUM_LEDS +: NUM_LEDS];
            assign slot_con[g] = CONNECTED_IN[g*NUM_LEDS +: NUM_LEDS];
            // Live activity merged with anything held while the group was hidden.
            assign slot_act[g] = ACTIVITY_IN[g*NUM_LEDS +: NUM_LEDS]
                               | pending[g*NUM_LEDS +: NUM_LEDS];
            assign err_grp[g]  = |ERROR_IN[g*NUM_LEDS +: NUM_LEDS];
        end else begin : g_pad
            assign slot_err[g] = '0;
            assign slot_con[g] = '0;
            assign slot_act[g] = '0;
            assign err_grp[g]  = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Group selection helpers
    // ------------------------------------------------------------------------
    logic [GROUP_BITS-1:0] next_group;      // plain round-robin successor
    logic [GROUP_BITS-1:0] next_err_group;  // first errored group after group_q
    logic [GROUP_BITS-1:0] search_cand;
    logic                  search_found;
    logic                  any_err;

    assign next_group = (group_q == LAST_GROUP) ? '0 : group_q + GROUP_BITS'(1);
    assign any_err    = |err_grp;

    // Cyclic search starting at group_q+1 and ending at group_q itself, so a
    // lone errored group that is already selected is chosen again.
    always_comb begin
        next_err_group = group_q;
        search_found   = 1'b0;
        search_cand    = group_q;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            search_cand = (search_cand == LAST_GROUP) ? '0 : search_cand + GROUP_BITS'(1);
            if (!search_found && err_grp[search_cand]) begin
                next_err_group = search_cand;
                search_found   = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scheduler FSM: only moves on an end-of-animation pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            state   <= ST_SCAN;
            group_q <= '0;
            dwell_q <= '0;
        end else if (ANIMATION_REPEAT_IN) begin
            case (state)
                ST_SCAN: begin
                    if (any_err) begin
                        state   <= ST_ERROR;
                        group_q <= next_err_group;
                        dwell_q <= '0;
                    end else if (dwell_q == LAST_DWELL) begin
                        group_q <= next_group;
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + DWELL_BITS'(1);
                    end
                end
                ST_ERROR: begin
                    if (!any_err) begin
                        state   <= ST_SCAN;
                        group_q <= next_group;
                        dwell_q <= '0;
                    end else if (dwell_q == LAST_DWELL) begin
                        // Only errored groups are candidates here.
                        group_q <= next_err_group;
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + DWELL_BITS'(1);
                    end
                end
                default: begin
                    state   <= ST_SCAN;
                    group_q <= '0;
                    dwell_q <= '0;
                end
            endcase
        end
    end

    assign STATE_OUT = state;

    // ------------------------------------------------------------------------
    // Held activity. A device in the displayed group is cleared because its
    // activity goes straight out. Using the current group_q means a pulse
    // arriving on the very edge that selects its group is still captured, and
    // then replayed one edge later from the new group.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            pending <= '0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (group_q == GROUP_BITS'(g)) begin
                    pending[g*NUM_LEDS +: NUM_LEDS] <= '0;
                end else begin
                    pending[g*NUM_LEDS +: NUM_LEDS] <= pending[g*NUM_LEDS +: NUM_LEDS]
                                                     | ACTIVITY_IN[g*NUM_LEDS +: NUM_LEDS];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output register: every LED_* bit and GROUP_OUT come from the same
    // group_q sample, so they can never disagree about which group is shown.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            LED_ERROR_OUT     <= '0;
            LED_CONNECTED_OUT <= '0;
            LED_ACTIVITY_OUT  <= '0;
            GROUP_OUT         <= '0;
        end else begin
            LED_ERROR_OUT     <= slot_err[group_q];
            LED_CONNECTED_OUT <= slot_con[group_q];
            LED_ACTIVITY_OUT  <= slot_act[group_q];
            GROUP_OUT         <= group_q;
        end
    end

endmodule
